// File: rtl/wb_cmd_master_pkg.sv
// rtl/wb_cmd_master_pkg.sv - state encoding and default parameters for wb_cmd_master
package wb_cmd_master_pkg;

    localparam int ADR_W_DEF   = 4;
    localparam int TMO_CYC_DEF = 255;
    localparam int RTY_MAX_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone B4 pipelined initiator with retry and timeout
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int ADR_W   = ADR_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF,
    parameter int RTY_MAX = RTY_MAX_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADR_W-1:0]  cmd_adr_i,
    input  logic [3:0]        cmd_sel_i,
    input  logic [31:0]       cmd_dat_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_tmo_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADR_W+1:2]  wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    input  logic [31:0]       wb_dat_i
);

    localparam int TW = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
    localparam int RW = (RTY_MAX < 1) ? 1 : $clog2(RTY_MAX + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TMO_CYC);
    localparam logic [RW-1:0] RTY_LIM = RW'(RTY_MAX);

    state_t        state_q, state_d;
    logic          gap_q;
    logic [TW-1:0] tmo_q;
    logic [RW-1:0] rty_q;

    logic          accept, reissue, finish;
    logic          fin_err, fin_tmo;
    logic [31:0]   fin_dat;

    // gap_q marks the single idle-bus cycle between a retry and its reissue
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RSP);
    assign wb_cyc_o    = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && !gap_q;
    assign wb_stb_o    = (state_q == ST_REQ) && !gap_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reissue = 1'b0;
        finish  = 1'b0;
        fin_err = 1'b0;
        fin_tmo = 1'b0;
        fin_dat = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (!gap_q) begin
                    if (wb_err_i) begin
                        finish  = 1'b1;
                        fin_err = 1'b1;
                        state_d = ST_RSP;
                    end else if (wb_rty_i) begin
                        if (rty_q < RTY_LIM) begin
                            reissue = 1'b1;
                            state_d = ST_REQ;
                        end else begin
                            finish  = 1'b1;
                            fin_err = 1'b1;
                            state_d = ST_RSP;
                        end
                    end else if (wb_ack_i) begin
                        finish  = 1'b1;
                        fin_dat = wb_we_o ? 32'd0 : wb_dat_i;
                        state_d = ST_RSP;
                    end else if (tmo_q == TMO_LIM) begin
                        finish  = 1'b1;
                        fin_err = 1'b1;
                        fin_tmo = 1'b1;
                        state_d = ST_RSP;
                    end else if ((state_q == ST_REQ) && !wb_stall_i) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            gap_q     <= 1'b0;
            tmo_q     <= '0;
            rty_q     <= '0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_sel_o  <= '0;
            wb_dat_o  <= '0;
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b0;
            rsp_tmo_o <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= reissue;
            if (accept) begin
                wb_we_o  <= cmd_we_i;
                wb_adr_o <= cmd_adr_i;
                wb_sel_o <= cmd_sel_i;
                wb_dat_o <= cmd_dat_i;
                tmo_q    <= '0;
                rty_q    <= '0;
            end else if (reissue) begin
                tmo_q <= '0;
                rty_q <= rty_q + RW'(1);
            end else if (wb_cyc_o && (tmo_q != TMO_LIM)) begin
                tmo_q <= tmo_q + TW'(1);
            end
            // response fields persist until the next completion overwrites them
            if (finish) begin
                rsp_dat_o <= fin_dat;
                rsp_err_o <= fin_err;
                rsp_tmo_o <= fin_tmo;
            end
        end
    end

endmodule
